serial_word_receiver: RTL and testbench

Front-end receiver that deserialises a framed one-bit stream into 7-bit words and hands them to the 7-bit-input decode stage (`in[6:0]`) through a one-entry valid/ready output buffer. It checks the start, parity and stop bits, and discards bad frames with one-cycle error pulses. It flags overrun when a good frame completes while the buffer is still held.

---
 rtl/serial_word_receiver.sv | 91 +++++++++
 tb/tb_serial_word_receiver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Deserialises start/data/parity/stop frames into DATA_W-bit words behind a one-entry valid/ready buffer.
// Results register on the stop-bit edge; a full, unaccepted buffer drops the new good frame with an overrun pulse.
module serial_word_receiver #(
  parameter int DATA_W      = 7,
  parameter bit PARITY_EVEN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic              ones_odd;
  logic              parity_ok;

  assign ones_odd  = ^{shift, par_bit};
  assign parity_ok = PARITY_EVEN ? !ones_odd : ones_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      if (word_valid && word_ready)
        word_valid <= 1'b0;
      if (rx_en) begin
        case (state)
          IDLE: begin
            if (!rx_bit) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shift[cnt] <= rx_bit;
            // Counter parks on the last index rather than wrapping.
            if (cnt == CW'(DATA_W - 1))
              state <= PARITY;
            else
              cnt <= cnt + 1'b1;
          end
          PARITY: begin
            par_bit <= rx_bit;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!rx_bit)
              frame_err <= 1'b1;
            else if (!parity_ok)
              parity_err <= 1'b1;
            else if (!word_valid || word_ready) begin
              // Load overrides the clear above when the old word leaves on this edge.
              word_out   <= shift;
              word_valid <= 1'b1;
            end else
              overrun <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: frame table, hand-built corner sequences and randomized frames vs a frame-level model.
module tb_serial_word_receiver;

  localparam int W = 7;
  localparam bit PAR_EVEN = 1'b1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_en = 1'b0;
  logic         rx_bit = 1'b1;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(.DATA_W(W), .PARITY_EVEN(PAR_EVEN)) dut (
    .clk(clk), .reset(reset), .rx_en(rx_en), .rx_bit(rx_bit),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  // Frame-level reference: collect the bits of a frame, evaluate it once complete.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_word = '0;
  bit           m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  bit           frame_q[$];

  function automatic void model_edge();
    bit           pv;
    int           ones;
    logic [W-1:0] d;
    bit           par_ok;
    pv = m_valid;
    m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    if (reset) begin
      m_valid = 1'b0; m_word = '0; frame_q.delete();
      return;
    end
    if (m_valid && word_ready) m_valid = 1'b0;
    if (rx_en) begin
      if (frame_q.size() != 0 || rx_bit == 1'b0) frame_q.push_back(rx_bit);
      if (frame_q.size() == W + 3) begin
        ones = 0; d = '0;
        for (int i = 0; i < W; i++) begin
          d[i] = frame_q[1+i];
          ones += int'(frame_q[1+i]);
        end
        ones += int'(frame_q[W+1]);
        par_ok = PAR_EVEN ? (ones % 2 == 0) : (ones % 2 == 1);
        if (!frame_q[W+2]) m_ferr = 1'b1;
        else if (!par_ok) m_perr = 1'b1;
        else if (!pv || word_ready) begin m_word = d; m_valid = 1'b1; end
        else m_ovr = 1'b1;
        frame_q.delete();
      end
    end
  endfunction

  function automatic bit good_par(input logic [W-1:0] d);
    return PAR_EVEN ? ^d : ~^d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, then compare all outputs just after the edge.
  task automatic cycle(input bit en, input bit b);
    rx_en = en; rx_bit = b;
    model_edge();
    @(posedge clk); #1;
    check("model word_valid", 32'(word_valid), 32'(m_valid));
    check("model word_out",   32'(word_out),   32'(m_word));
    check("model parity_err", 32'(parity_err), 32'(m_perr));
    check("model frame_err",  32'(frame_err),  32'(m_ferr));
    check("model overrun",    32'(overrun),    32'(m_ovr));
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit par, input bit stp,
                            input bit rdy_body, input bit rdy_stop,
                            input int gap_after, input int gap_len);
    logic [W+2:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int idx = 0; idx < W + 3; idx++) begin
      word_ready = (idx == W + 2) ? rdy_stop : rdy_body;
      cycle(1'b1, bits[idx]);
      if (idx == gap_after)
        for (int g = 0; g < gap_len; g++) cycle(1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    bit par, stp, rdy_body, rdy_stop;
    bit e_valid;
    logic [W-1:0] e_word;
    bit e_perr, e_ferr, e_ovr;
  } vec_t;

  vec_t vecs[11];
  int   mon_words, mon_errs;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (word_valid && word_ready && word_out == 7'h7F) mon_words++;
      if (parity_err || frame_err || overrun) mon_errs++;
    end
  end

  initial begin
    vecs[0]  = '{7'h55, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{7'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'h55, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{7'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'h55, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{7'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{7'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{7'h2A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'h55, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{7'h2A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{7'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{7'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{7'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{7'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    check("reset word_valid", 32'(word_valid), 32'd0);
    check("reset word_out", 32'(word_out), 32'd0);
    check("reset pulses", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    reset = 1'b0;
    word_ready = 1'b1;
    cycle(1'b1, 1'b1);

    // Table: back-to-back frames, expectations checked on the cycle after each stop edge.
    for (int v = 0; v < 11; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stp, vecs[v].rdy_body, vecs[v].rdy_stop, -1, 0);
      check($sformatf("vec%0d word_valid", v), 32'(word_valid), 32'(vecs[v].e_valid));
      check($sformatf("vec%0d word_out", v), 32'(word_out), 32'(vecs[v].e_word));
      check($sformatf("vec%0d parity_err", v), 32'(parity_err), 32'(vecs[v].e_perr));
      check($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].e_ferr));
      check($sformatf("vec%0d overrun", v), 32'(overrun), 32'(vecs[v].e_ovr));
    end

    // Gapped rx_en after data bit 3, then the word must last one cycle only.
    word_ready = 1'b1;
    cycle(1'b1, 1'b1);
    send_frame(7'h55, 1'b0, 1'b1, 1'b1, 1'b1, 4, 3);
    check("gap word_valid", 32'(word_valid), 32'd1);
    check("gap word_out", 32'(word_out), 32'h55);
    cycle(1'b1, 1'b1);
    check("gap valid one cycle", 32'(word_valid), 32'd0);

    // Reset mid-frame while a word is held: word dropped, partial frame abandoned.
    send_frame(7'h01, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    check("held before reset", 32'(word_valid), 32'd1);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    reset = 1'b1;
    cycle(1'b1, 1'b0);
    reset = 1'b0;
    check("reset drops word", 32'(word_valid), 32'd0);
    mon_words = 0; mon_errs = 0;
    mon_en = 1'b1;
    word_ready = 1'b1;
    send_frame(7'h7F, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
    mon_en = 1'b0;
    check("reset-then-7F words", 32'(mon_words), 32'd1);
    check("reset-then-7F errors", 32'(mon_errs), 32'd0);

    // Randomized frames with gaps, noise and random backpressure.
    for (int f = 0; f < 250; f++) begin
      logic [W-1:0] d;
      bit p, s;
      logic [W+2:0] bits;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        word_ready = 1'($urandom_range(0, 1));
        cycle(1'($urandom_range(0, 1)), 1'b1);
      end
      d = W'($urandom);
      p = good_par(d) ^ ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 9) != 0);
      bits = {s, p, d, 1'b0};
      for (int idx = 0; idx < W + 3; idx++) begin
        while ($urandom_range(0, 3) == 0) begin
          word_ready = 1'($urandom_range(0, 1));
          cycle(1'b0, 1'($urandom_range(0, 1)));
        end
        word_ready = 1'($urandom_range(0, 1));
        cycle(1'b1, bits[idx]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
